// File: rtl/jtag_scan_master.sv
// -----------------------------------------------------------------------------
// jtag_scan_master
//
// JTAG initiator. A single request turns into a complete TMS walk:
// Run-Test/Idle -> Shift-IR -> Run-Test/Idle -> Shift-DR -> Run-Test/Idle,
// or into a five-ones TAP reset walk that ends in Run-Test/Idle.
// TCK is produced from clk_i: CLK_DIV cycles low, then CLK_DIV cycles high.
// TMS/TDI change on the clk_i edge where TCK falls, and TDO is sampled on the
// clk_i edge where TCK rises.
//
// Ports
//   clk_i, rst_i        system clock, asynchronous active-high reset
//   start_i             one-cycle request for an IR+DR scan
//   reset_tap_i         one-cycle request for a TAP reset walk (wins over start_i)
//   ir_i, dr_i          shift data, LSB first, latched at acceptance
//   dr_len_i            DR bit count (0 = IR-only, clamped to DR_W)
//   busy_o, done_o      busy from acceptance to done; done is a one-cycle pulse
//   dr_o                captured TDO bits, bit k = k-th DR shift bit
//   tck_o, tms_o, tdi_o JTAG outputs
//   tdo_i               JTAG TDO (synchronous to tck_o)
// -----------------------------------------------------------------------------
module jtag_scan_master #(
    parameter int CLK_DIV = 4,
    parameter int IR_W    = 8,
    parameter int DR_W    = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      reset_tap_i,
    input  logic [IR_W-1:0]           ir_i,
    input  logic [DR_W-1:0]           dr_i,
    input  logic [$clog2(DR_W+1)-1:0] dr_len_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [DR_W-1:0]           dr_o,
    output logic                      tck_o,
    output logic                      tms_o,
    output logic                      tdi_o,
    input  logic                      tdo_i
);

    localparam int LEN_W = $clog2(DR_W + 1);
    localparam int MAX_C = (IR_W > DR_W) ? ((IR_W > 6) ? IR_W : 6)
                                         : ((DR_W > 6) ? DR_W : 6);
    localparam int CNT_W = $clog2(MAX_C + 1);
    localparam int DIV_W = $clog2(CLK_DIV + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] IR_LAST  = CNT_W'(IR_W - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DR_W);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_RST_WALK = 4'd1,
        ST_IR_PRE   = 4'd2,
        ST_IR_SHIFT = 4'd3,
        ST_IR_POST  = 4'd4,
        ST_DR_PRE   = 4'd5,
        ST_DR_SHIFT = 4'd6,
        ST_DR_POST  = 4'd7,
        ST_DONE     = 4'd8
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tck_q, tck_d;
    logic                tms_q, tms_d;
    logic                tdi_q, tdi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [IR_W-1:0]     ir_q, ir_d;
    logic [DR_W-1:0]     dr_q, dr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DR_W-1:0]     dr_out_q, dr_out_d;

    state_t              nxt_state_s;
    logic [CNT_W-1:0]    nxt_cnt_s;
    logic [CNT_W-1:0]    cur_last_s;
    logic                tick_s;

    // Index of the final TCK cycle spent in a scan state.
    function automatic logic [CNT_W-1:0] last_cnt(input state_t s, input logic [LEN_W-1:0] len);
        case (s)
            ST_RST_WALK: last_cnt = CNT_W'(5);
            ST_IR_PRE:   last_cnt = CNT_W'(3);
            ST_IR_SHIFT: last_cnt = IR_LAST;
            ST_DR_PRE:   last_cnt = CNT_W'(2);
            ST_DR_SHIFT: last_cnt = CNT_W'(len) - CNT_W'(1);
            default:     last_cnt = CNT_W'(1);
        endcase
    endfunction

    // TMS level for TCK cycle c of state s.
    function automatic logic pos_tms(input state_t s, input logic [CNT_W-1:0] c,
                                     input logic [CNT_W-1:0] last);
        case (s)
            ST_RST_WALK:              pos_tms = (c != last);
            ST_IR_PRE:                pos_tms = (c < CNT_W'(2));
            ST_IR_SHIFT, ST_DR_SHIFT: pos_tms = (c == last);
            ST_IR_POST, ST_DR_PRE,
            ST_DR_POST:               pos_tms = (c == CNT_W'(0));
            default:                  pos_tms = 1'b0;
        endcase
    endfunction

    // TDI level for TCK cycle c of state s; only the shift states carry data.
    function automatic logic pos_tdi(input state_t s, input logic [CNT_W-1:0] c,
                                     input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr);
        logic [IR_W-1:0] ir_sh;
        logic [DR_W-1:0] dr_sh;
        ir_sh = ir >> c;
        dr_sh = dr >> c;
        case (s)
            ST_IR_SHIFT: pos_tdi = ir_sh[0];
            ST_DR_SHIFT: pos_tdi = dr_sh[0];
            default:     pos_tdi = 1'b0;
        endcase
    endfunction

    // Next-state, TCK phase generation, TMS/TDI sequencing and TDO capture.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        tck_d       = tck_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ir_d        = ir_q;
        dr_d        = dr_q;
        len_d       = len_q;
        dr_out_d    = dr_out_q;
        nxt_state_s = state_q;
        nxt_cnt_s   = cnt_q;
        cur_last_s  = last_cnt(state_q, len_q);
        tick_s      = (div_q == DIV_LAST);

        case (state_q)
            ST_IDLE: begin
                tck_d = 1'b0;
                tms_d = 1'b0;
                tdi_d = 1'b0;
                div_d = '0;
                cnt_d = '0;
                if (reset_tap_i) begin
                    state_d = ST_RST_WALK;
                    busy_d  = 1'b1;
                    tms_d   = 1'b1;
                end else if (start_i) begin
                    state_d  = ST_IR_PRE;
                    busy_d   = 1'b1;
                    tms_d    = 1'b1;
                    ir_d     = ir_i;
                    dr_d     = dr_i;
                    len_d    = (dr_len_i > LEN_MAX) ? LEN_MAX : dr_len_i;
                    dr_out_d = '0;
                end else begin
                    busy_d = 1'b0;
                end
            end

            // TCK is parked low here for CLK_DIV cycles before done pulses.
            ST_DONE: begin
                tck_d = 1'b0;
                tms_d = 1'b0;
                tdi_d = 1'b0;
                if (tick_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            // All TCK-driven scan states share the phase machinery.
            default: begin
                if (!tick_s) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (!tck_q) begin
                        // Rising TCK: TDO is valid now.
                        tck_d = 1'b1;
                        if (state_q == ST_DR_SHIFT) begin
                            dr_out_d = dr_out_q | (DR_W'(tdo_i) << cnt_q);
                        end else begin
                            dr_out_d = dr_out_q;
                        end
                    end else begin
                        // Falling TCK: step to the next position and present its TMS/TDI.
                        tck_d = 1'b0;
                        if (cnt_q != cur_last_s) begin
                            nxt_state_s = state_q;
                            nxt_cnt_s   = cnt_q + CNT_W'(1);
                        end else begin
                            nxt_cnt_s = '0;
                            case (state_q)
                                ST_IR_PRE:   nxt_state_s = ST_IR_SHIFT;
                                ST_IR_SHIFT: nxt_state_s = ST_IR_POST;
                                ST_IR_POST:  nxt_state_s = (len_q == LEN_W'(0)) ? ST_DONE : ST_DR_PRE;
                                ST_DR_PRE:   nxt_state_s = ST_DR_SHIFT;
                                ST_DR_SHIFT: nxt_state_s = ST_DR_POST;
                                default:     nxt_state_s = ST_DONE;
                            endcase
                        end
                        state_d = nxt_state_s;
                        cnt_d   = nxt_cnt_s;
                        tms_d   = pos_tms(nxt_state_s, nxt_cnt_s, last_cnt(nxt_state_s, len_q));
                        tdi_d   = pos_tdi(nxt_state_s, nxt_cnt_s, ir_q, dr_q);
                    end
                end
            end
        endcase
    end

    // State and output registers; TMS idles high while in reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            cnt_q    <= '0;
            tck_q    <= 1'b0;
            tms_q    <= 1'b1;
            tdi_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ir_q     <= '0;
            dr_q     <= '0;
            len_q    <= '0;
            dr_out_q <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            tck_q    <= tck_d;
            tms_q    <= tms_d;
            tdi_q    <= tdi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ir_q     <= ir_d;
            dr_q     <= dr_d;
            len_q    <= len_d;
            dr_out_q <= dr_out_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign dr_o   = dr_out_q;
    assign tck_o  = tck_q;
    assign tms_o  = tms_q;
    assign tdi_o  = tdi_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// -----------------------------------------------------------------------------
// Bench for jtag_scan_master (CLK_DIV=2, IR_W=4, DR_W=8).
// A behavioural 1149.1 TAP (IDCODE=0x1 selects an 8-bit 0xA5 register, other
// codes select BYPASS) or a one-TCK TDI->TDO loopback drives tdo. Each
// accepted request pushes its hand-derived expectation into a queue; a
// separate monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_jtag_scan_master;

    localparam int CLK_DIV = 2;
    localparam int IR_W    = 4;
    localparam int DR_W    = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rtap = 1'b0;
    logic [3:0] ir = 4'h0;
    logic [7:0] dr = 8'h00;
    logic [3:0] dr_len = 4'd0;
    logic       busy, done, tck, tms, tdi, tdo;
    logic [7:0] dr_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    jtag_scan_master #(.CLK_DIV(CLK_DIV), .IR_W(IR_W), .DR_W(DR_W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .reset_tap_i(rtap),
        .ir_i(ir), .dr_i(dr), .dr_len_i(dr_len),
        .busy_o(busy), .done_o(done), .dr_o(dr_o),
        .tck_o(tck), .tms_o(tms), .tdi_o(tdi), .tdo_i(tdo)
    );

    // ---------------- observation counters ----------------
    int       cyc = 0;
    int       tck_cnt = 0;
    logic [7:0] tms_hist = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge tck) begin
        tck_cnt  <= tck_cnt + 1;
        tms_hist <= {tms_hist[6:0], tms};
    end

    // ---------------- TAP model ----------------
    typedef enum logic [3:0] {
        T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PAUDR, T_EX2DR, T_UPDR,
        T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAUIR, T_EX2IR, T_UPIR
    } tap_t;

    tap_t       tap_st = T_TLR;
    logic [3:0] ir_reg = 4'h0;
    logic [3:0] ir_sr = 4'h0;
    logic [7:0] dr_sr = 8'h00;
    logic       tap_tdo = 1'b0;
    logic       lb_q = 1'b0;
    logic       lb_mode = 1'b0;
    int shir_cnt = 0, shdr_cnt = 0, capdr_cnt = 0, updir_cnt = 0;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            T_TLR:   tap_next = m ? T_TLR   : T_RTI;
            T_RTI:   tap_next = m ? T_SELDR : T_RTI;
            T_SELDR: tap_next = m ? T_SELIR : T_CAPDR;
            T_CAPDR: tap_next = m ? T_EX1DR : T_SHDR;
            T_SHDR:  tap_next = m ? T_EX1DR : T_SHDR;
            T_EX1DR: tap_next = m ? T_UPDR  : T_PAUDR;
            T_PAUDR: tap_next = m ? T_EX2DR : T_PAUDR;
            T_EX2DR: tap_next = m ? T_UPDR  : T_SHDR;
            T_UPDR:  tap_next = m ? T_SELDR : T_RTI;
            T_SELIR: tap_next = m ? T_TLR   : T_CAPIR;
            T_CAPIR: tap_next = m ? T_EX1IR : T_SHIR;
            T_SHIR:  tap_next = m ? T_EX1IR : T_SHIR;
            T_EX1IR: tap_next = m ? T_UPIR  : T_PAUIR;
            T_PAUIR: tap_next = m ? T_EX2IR : T_PAUIR;
            T_EX2IR: tap_next = m ? T_UPIR  : T_SHIR;
            default: tap_next = m ? T_SELDR : T_RTI;
        endcase
    endfunction

    always @(posedge tck) begin
        case (tap_st)
            T_TLR:   ir_reg <= 4'h1;
            T_CAPIR: ir_sr <= 4'b0001;
            T_SHIR:  begin ir_sr <= {tdi, ir_sr[3:1]}; shir_cnt <= shir_cnt + 1; end
            T_UPIR:  begin ir_reg <= ir_sr; updir_cnt <= updir_cnt + 1; end
            T_CAPDR: begin capdr_cnt <= capdr_cnt + 1; dr_sr <= (ir_reg == 4'h1) ? 8'hA5 : 8'h00; end
            T_SHDR: begin
                shdr_cnt <= shdr_cnt + 1;
                if (ir_reg == 4'h1) dr_sr <= {tdi, dr_sr[7:1]};
                else                dr_sr <= {7'b0, tdi};
            end
            default: ;
        endcase
        tap_st <= tap_next(tap_st, tms);
        lb_q   <= tdi;
    end

    always @(negedge tck) begin
        tap_tdo <= (tap_st == T_SHIR) ? ir_sr[0] : ((tap_st == T_SHDR) ? dr_sr[0] : 1'b0);
    end

    assign tdo = lb_mode ? lb_q : tap_tdo;

    // ---------------- scoreboard ----------------
    typedef struct {
        string name;
        int acc_cyc, tck0, shir0, shdr0, capdr0, updir0;
        int exp_dr, exp_n, exp_lat, exp_shir, exp_shdr, exp_capdr, exp_updir, exp_ir, exp_tms6;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one request at a negedge; push the expectation once it is accepted.
    task automatic issue(input string name, input logic do_start, input logic do_rtap,
                         input logic [3:0] ir_v, input logic [7:0] dr_v, input logic [3:0] len_v,
                         input int exp_dr, input int exp_n, input int exp_shir, input int exp_shdr,
                         input int exp_capdr, input int exp_updir, input int exp_ir, input int exp_tms6);
        exp_t e;
        @(negedge clk);
        start = do_start; rtap = do_rtap; ir = ir_v; dr = dr_v; dr_len = len_v;
        @(posedge clk); #1;
        start = 1'b0; rtap = 1'b0;
        e.name = name;       e.acc_cyc = cyc;     e.tck0 = tck_cnt;
        e.shir0 = shir_cnt;  e.shdr0 = shdr_cnt;  e.capdr0 = capdr_cnt; e.updir0 = updir_cnt;
        e.exp_dr = exp_dr;   e.exp_n = exp_n;     e.exp_lat = 2 * CLK_DIV * exp_n + CLK_DIV;
        e.exp_shir = exp_shir; e.exp_shdr = exp_shdr; e.exp_capdr = exp_capdr;
        e.exp_updir = exp_updir; e.exp_ir = exp_ir; e.exp_tms6 = exp_tms6;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            if (sb.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: got no done_o, expected done within 1000 cycles", name);
            sb.delete();
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_done: got done_o=1, expected no pending request");
                end else begin
                    e = sb.pop_front();
                    check({e.name, "/dr_o"},    int'(dr_o), e.exp_dr);
                    check({e.name, "/latency"}, cyc - e.acc_cyc, e.exp_lat);
                    check({e.name, "/tck_cycles"}, tck_cnt - e.tck0, e.exp_n);
                    check({e.name, "/tms_tail"}, int'(tms_hist[5:0]), e.exp_tms6);
                    check({e.name, "/shift_ir"}, shir_cnt - e.shir0, e.exp_shir);
                    check({e.name, "/shift_dr"}, shdr_cnt - e.shdr0, e.exp_shdr);
                    check({e.name, "/capture_dr"}, capdr_cnt - e.capdr0, e.exp_capdr);
                    check({e.name, "/update_ir"}, updir_cnt - e.updir0, e.exp_updir);
                    check({e.name, "/tap_end"}, int'(tap_st), int'(T_RTI));
                    check({e.name, "/tap_ir"}, int'(ir_reg), e.exp_ir);
                    check({e.name, "/busy_at_done"}, int'(busy), 0);
                end
            end
        end
    end

    // Watchdog against a stuck run.
    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test, expected finish within 300 us");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst/tck", int'(tck), 0);
        check("rst/tms", int'(tms), 1);
        check("rst/tdi", int'(tdi), 0);
        check("rst/busy", int'(busy), 0);
        check("rst/done", int'(done), 0);
        check("rst/dr_o", int'(dr_o), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst/tms_release", int'(tms), 0);

        // TAP reset walk from Test-Logic-Reset: 6 TCK, 26 clk latency.
        issue("rst_walk", 1'b0, 1'b1, 4'h0, 8'h00, 4'd0, 'h00, 6, 0, 0, 0, 0, 1, 'b111110);
        wait_done("rst_walk");

        // IDCODE scan: ir=1, 8 DR bits, 23 TCK.
        issue("idcode", 1'b1, 1'b0, 4'h1, 8'h00, 4'd8, 'hA5, 23, 4, 8, 1, 1, 1, 'b000110);
        wait_done("idcode");

        // A start while busy is ignored and does not change the scan.
        issue("busy_ignore", 1'b1, 1'b0, 4'h1, 8'h00, 4'd8, 'hA5, 23, 4, 8, 1, 1, 1, 'b000110);
        repeat (10) @(negedge clk);
        start = 1'b1; ir = 4'hF; dr = 8'hFF; dr_len = 4'd2;
        @(negedge clk);
        start = 1'b0;
        check("busy_ignore/busy", int'(busy), 1);
        wait_done("busy_ignore");

        // Simultaneous start and reset_tap: the reset walk wins, dr_o untouched.
        issue("both_req", 1'b1, 1'b1, 4'h1, 8'h00, 4'd8, 'hA5, 6, 0, 0, 0, 0, 1, 'b111110);
        wait_done("both_req");

        // IR-only scan selecting BYPASS: 10 TCK, dr_o cleared.
        issue("ir_only", 1'b1, 1'b0, 4'hF, 8'h5A, 4'd0, 'h00, 10, 4, 0, 0, 1, 'hF, 'b000110);
        wait_done("ir_only");

        // Loopback: bit k returns dr bit k-1, bit 0 sees the DR_PRE TDI (0).
        lb_mode = 1'b1;
        issue("loopback", 1'b1, 1'b0, 4'h1, 8'h3C, 4'd8, 'h78, 23, 4, 8, 1, 1, 1, 'b000110);
        wait_done("loopback");
        issue("clamp", 1'b1, 1'b0, 4'h1, 8'h3C, 4'd9, 'h78, 23, 4, 8, 1, 1, 1, 'b000110);
        wait_done("clamp");
        lb_mode = 1'b0;

        // Reset in the second IR_SHIFT cycle (TDI=ir[1]=1 at that moment).
        issue("aborted", 1'b1, 1'b0, 4'hE, 8'h00, 4'd8, 'h00, 23, 4, 8, 1, 1, 'hE, 'b000110);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("abort/tdi_before", int'(tdi), 1);
        rst = 1'b1;
        #1;
        check("abort/tck", int'(tck), 0);
        check("abort/tms", int'(tms), 1);
        check("abort/tdi", int'(tdi), 0);
        check("abort/busy", int'(busy), 0);
        check("abort/dr_o", int'(dr_o), 0);
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;

        // TAP was left in Shift-IR: walk passes Exit1-IR and Update-IR on the way out.
        issue("recover_walk", 1'b0, 1'b1, 4'h0, 8'h00, 4'd0, 'h00, 6, 1, 0, 0, 1, 1, 'b111110);
        wait_done("recover_walk");
        issue("recover_scan", 1'b1, 1'b0, 4'h1, 8'h00, 4'd8, 'hA5, 23, 4, 8, 1, 1, 1, 'b000110);
        wait_done("recover_scan");

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
